bldc_commutator: RTL and testbench
==================================

# bldc_commutator

Six-step commutation stage for the BLDC controller. Sits directly downstream of the PWM generator: takes its PWM output, three Hall sensor inputs, enable and direction, and drives the six inverter gate signals with dead-time insertion and fault protection. High-side switches are chopped by PWM; low-side switches are held on for the whole sector.

## Interface
Parameters:
- DEADTIME, 4: cycles with all gates off at every commutation change (1..15).
- DEBOUNCE, 3: consecutive stable cycles required to accept a Hall code (1..15).
- STALL_LIMIT, 50000: cycles without an accepted sector change before stall fault (16-bit).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- PWM  in  1  chopping signal from PWM generator.
- EN  in  1  run enable.
- DIR  in  1  0 = forward, 1 = reverse.
- HALL  in  3  raw Hall inputs {Ha,Hb,Hc}, asynchronous.
- AH, AL, BH, BL, CH, CL  out  1 each  gate drives, registered.
- SECTOR  out  3  accepted sector 0..5.
- STEP  out  1  one-cycle pulse per accepted adjacent sector change.
- FAULT  out  1  sticky fault flag.

## Operation
- HALL passes through a 2-FF synchroniser, then a debouncer: accepted code updates when the synced code has been identical for DEBOUNCE consecutive cycles.
- Decode: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5; 000 and 111 are invalid.
- Forward pattern (high phase / low phase): s0 A/B, s1 A/C, s2 B/C, s3 B/A, s4 C/A, s5 C/B. DIR=1 swaps the two phases in each pair.
- RUN drive: selected XH = PWM; selected XL = 1; all other gates 0. XH and XL of the same phase are never both 1.
- FSM states:
  - IDLE: all gates 0. Moves to DEAD when EN=1 and the accepted code is valid.
  - DEAD: all gates 0 for DEADTIME cycles, then RUN.
  - RUN: applies the pattern.
    - EN=0: go to IDLE.
    - Accepted sector change of ±1 (mod 6), or DIR toggle: go to DEAD.
  - FAULT: all gates 0, FAULT=1. Leaves only on RST.
- Faults, checked in DEAD and RUN:
  - Invalid accepted code.
  - Sector jump of 2 or 3 (mod 6).
  - Stall counter reaching STALL_LIMIT.
- Stall counter:
  - Cleared in IDLE and on every accepted sector change.
  - Increments every cycle in DEAD and RUN.
  - Saturates; no wrap.
- STEP fires only for a ±1 change while in DEAD or RUN.
- SECTOR tracks the last valid accepted code in every state. Invalid codes do not update it.
- Reset values: all gates 0, SECTOR 0, STEP 0, FAULT 0, state IDLE, all counters 0, synchroniser and debouncer cleared to 000.

## Timing
- HALL pin change to SECTOR/STEP update: 2 + DEBOUNCE cycles.
- SECTOR change to gates 0: next cycle.
- New pattern first appears DEADTIME cycles after that.
- PWM to XH: 1 cycle (registered).
- EN falling: gates 0 on the next cycle.
- EN rising: first drive after 1 + DEADTIME cycles, given a valid code.
- Simultaneous events in one cycle:
  - Fault condition and sector change: FAULT wins.
  - EN=0 and sector change: IDLE wins.
  - DIR toggle during DEAD: restarts the DEADTIME count.
- RST mid-operation: gates 0 and FAULT cleared on the cycle following the RST edge.

## Test plan
- Reset, then EN=1 with HALL=101, DIR=0, PWM=1, DEADTIME=4, DEBOUNCE=3:
  - SECTOR=0 five cycles after HALL settles.
  - AH=1, BL=1 after 4 more dead cycles.
  - All other gates 0.
- Forward rotation 101→100→110→010→011→001→101, 200 cycles per step:
  - Six STEP pulses.
  - Patterns A/C, B/C, B/A, C/A, C/B, A/B in that order.
  - Each change preceded by exactly 4 all-zero cycles.
- DIR=1 in sector 2:
  - 4 dead cycles, then BL=1 and CH follows PWM.
  - PWM toggling every cycle gives CH toggling one cycle late.
- Glitches:
  - HALL glitch of 2 cycles (shorter than DEBOUNCE): no SECTOR change, no STEP, gates unchanged.
  - HALL=111 held for 3+ cycles: FAULT=1, gates 0.
  - FAULT persists after EN toggles; clears only on RST.
- Sector jump 0→2 (101→110): FAULT=1.
- Stall: STALL_LIMIT=100 with constant HALL gives FAULT exactly 100 cycles after entering DEAD.
- EN dropped mid-RUN: gates 0 on the next cycle and state returns to IDLE.

Source files
------------

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation: Hall sync/debounce, sector decode, dead-time FSM,
// PWM-chopped high side, stall and sequence fault detection.
module bldc_commutator #(
    parameter int unsigned DEADTIME    = 4,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned STALL_LIMIT = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PWM,
    input  logic       EN,
    input  logic       DIR,
    input  logic [2:0] HALL,
    output logic       AH,
    output logic       AL,
    output logic       BH,
    output logic       BL,
    output logic       CH,
    output logic       CL,
    output logic [2:0] SECTOR,
    output logic       STEP,
    output logic       FAULT
);

    typedef enum logic [1:0] {IDLE, DEAD, RUN, FLT} state_t;

    localparam logic [3:0]  DT = 4'(DEADTIME);
    localparam logic [3:0]  DB = 4'(DEBOUNCE);
    localparam logic [16:0] SL = 17'(STALL_LIMIT);

    state_t      state;
    logic [2:0]  hall_s1, hall_s2, cand, acc;
    logic [3:0]  dbcnt, dcnt;
    logic [15:0] stall;
    logic        dir_q;
    logic [5:0]  gates;

    logic        take, new_valid, go_valid, sec_chg, adj, jump;
    logic        active, stall_hit, fault_now, dir_chg;
    logic [2:0]  new_sec, diff, hp, lp, hi, lo;
    logic [3:0]  sum;
    logic [5:0]  drive;

    function automatic logic [3:0] decode(input logic [2:0] h);
        case (h)
            3'b101:  return {1'b1, 3'd0};
            3'b100:  return {1'b1, 3'd1};
            3'b110:  return {1'b1, 3'd2};
            3'b010:  return {1'b1, 3'd3};
            3'b011:  return {1'b1, 3'd4};
            3'b001:  return {1'b1, 3'd5};
            default: return 4'b0000;
        endcase
    endfunction

    // The debounce acceptance is consumed combinationally so SECTOR, STEP and the
    // FSM all react on the same edge the new code is accepted.
    always_comb begin
        if (hall_s2 != cand) take = (DB == 4'd1);
        else                 take = (dbcnt == DB - 4'd1);
        {new_valid, new_sec} = decode(hall_s2);
        go_valid  = take ? new_valid : (acc != 3'b000 && acc != 3'b111);
        sum       = {1'b0, new_sec} + 4'd6 - {1'b0, SECTOR};
        diff      = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        sec_chg   = take && new_valid && (diff != 3'd0);
        adj       = sec_chg && (diff == 3'd1 || diff == 3'd5);
        jump      = sec_chg && !adj;
        active    = (state == DEAD) || (state == RUN);
        stall_hit = ({1'b0, stall} + 17'd1) >= SL;
        fault_now = active && ((take && !new_valid) || jump || stall_hit);
        dir_chg   = (DIR != dir_q);

        hp = 3'b000;
        lp = 3'b000;
        case (SECTOR)
            3'd0: begin hp = 3'b100; lp = 3'b010; end
            3'd1: begin hp = 3'b100; lp = 3'b001; end
            3'd2: begin hp = 3'b010; lp = 3'b001; end
            3'd3: begin hp = 3'b010; lp = 3'b100; end
            3'd4: begin hp = 3'b001; lp = 3'b100; end
            3'd5: begin hp = 3'b001; lp = 3'b010; end
            default: ;
        endcase
        hi    = DIR ? lp : hp;
        lo    = DIR ? hp : lp;
        drive = {hi[2] & PWM, lo[2], hi[1] & PWM, lo[1], hi[0] & PWM, lo[0]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hall_s1 <= '0;
            hall_s2 <= '0;
            cand    <= '0;
            acc     <= '0;
            dbcnt   <= '0;
            dcnt    <= '0;
            stall   <= '0;
            dir_q   <= 1'b0;
            gates   <= '0;
            SECTOR  <= '0;
            STEP    <= 1'b0;
            FAULT   <= 1'b0;
            state   <= IDLE;
        end else begin
            hall_s1 <= HALL;
            hall_s2 <= hall_s1;
            dir_q   <= DIR;

            if (hall_s2 != cand) begin
                cand  <= hall_s2;
                dbcnt <= 4'd1;
            end else if (dbcnt < DB) begin
                dbcnt <= dbcnt + 4'd1;
            end
            if (take) acc <= hall_s2;
            if (take && new_valid) SECTOR <= new_sec;
            STEP <= adj && active && !fault_now;

            if (state == IDLE || sec_chg) stall <= '0;
            else if (active && stall != '1) stall <= stall + 16'd1;

            gates <= '0;
            case (state)
                IDLE: begin
                    if (EN && go_valid) begin
                        state <= DEAD;
                        dcnt  <= '0;
                    end
                end
                DEAD: begin
                    if (fault_now) begin
                        state <= FLT;
                        FAULT <= 1'b1;
                    end else if (!EN) begin
                        state <= IDLE;
                    end else if (adj || dir_chg) begin
                        dcnt <= '0;
                    end else if (dcnt == DT - 4'd1) begin
                        state <= RUN;
                        gates <= drive;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                RUN: begin
                    if (fault_now) begin
                        state <= FLT;
                        FAULT <= 1'b1;
                    end else if (!EN) begin
                        state <= IDLE;
                    end else if (adj || dir_chg) begin
                        state <= DEAD;
                        dcnt  <= '0;
                    end else begin
                        gates <= drive;
                    end
                end
                default: FAULT <= 1'b1;
            endcase
        end
    end

    assign {AH, AL, BH, BL, CH, CL} = gates;

endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: timeline-based reference model of
// Hall acceptance latency, dead time and the six-step gate table.
module tb_bldc_commutator;

    localparam int DT   = 4;
    localparam int DB   = 3;
    localparam int SLIM = 100;

    logic       CLK = 1'b0;
    logic       RST, PWM, EN, DIR;
    logic [2:0] HALL;
    logic       AH, AL, BH, BL, CH, CL, STEP, FAULT;
    logic [2:0] SECTOR;
    logic       s_AH, s_AL, s_BH, s_BL, s_CH, s_CL, s_STEP, s_FAULT;
    logic [2:0] s_SECTOR;
    logic [5:0] gates;

    int chk  = 0;
    int pass = 0;
    int cur_sec;
    logic cur_dir;

    logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph [6] = '{1, 2, 2, 0, 0, 1};

    assign gates = {AH, AL, BH, BL, CH, CL};

    bldc_commutator #(.DEADTIME(DT), .DEBOUNCE(DB), .STALL_LIMIT(50000)) dut (
        .CLK(CLK), .RST(RST), .PWM(PWM), .EN(EN), .DIR(DIR), .HALL(HALL),
        .AH(AH), .AL(AL), .BH(BH), .BL(BL), .CH(CH), .CL(CL),
        .SECTOR(SECTOR), .STEP(STEP), .FAULT(FAULT)
    );

    bldc_commutator #(.DEADTIME(DT), .DEBOUNCE(DB), .STALL_LIMIT(SLIM)) dut_s (
        .CLK(CLK), .RST(RST), .PWM(PWM), .EN(EN), .DIR(DIR), .HALL(HALL),
        .AH(s_AH), .AL(s_AL), .BH(s_BH), .BL(s_BL), .CH(s_CH), .CL(s_CL),
        .SECTOR(s_SECTOR), .STEP(s_STEP), .FAULT(s_FAULT)
    );

    always #5 CLK = ~CLK;

    // Phase 0/1/2 = A/B/C; gate vector is {AH,AL,BH,BL,CH,CL}.
    function automatic logic [5:0] pat(input int sec, input logic dir, input logic pwm);
        int h, l;
        logic [5:0] g;
        h = dir ? lo_ph[sec] : hi_ph[sec];
        l = dir ? hi_ph[sec] : lo_ph[sec];
        g = '0;
        g[5 - 2*h] = pwm;
        g[4 - 2*l] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; DIR = 1'b0; PWM = 1'b0; HALL = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        do_reset();
        chk++; if (gates !== 6'b0) $display("FAIL reset_gates: got %b expected 000000", gates); else pass++;
        chk++; if (SECTOR !== 3'd0) $display("FAIL reset_sector: got %0d expected 0", SECTOR); else pass++;
        chk++; if (STEP !== 1'b0) $display("FAIL reset_step: got %b expected 0", STEP); else pass++;
        chk++; if (FAULT !== 1'b0) $display("FAIL reset_fault: got %b expected 0", FAULT); else pass++;
    endtask

    task automatic test_startup();
        RST = 1'b0; HALL = 3'b101; EN = 1'b1; DIR = 1'b0; PWM = 1'b1;
        for (int c = 1; c < 2 + DB + DT; c++) begin
            tick();
            chk++; if (gates !== 6'b0) $display("FAIL startup_dead c=%0d: got %b expected 000000", c, gates); else pass++;
            if (c == 2 + DB) begin
                chk++; if (SECTOR !== 3'd0) $display("FAIL startup_sector: got %0d expected 0", SECTOR); else pass++;
            end
        end
        tick();
        chk++; if (gates !== 6'b100100) $display("FAIL startup_drive: got %b expected 100100", gates); else pass++;
        cur_sec = 0;
        cur_dir = 1'b0;
    endtask

    // Drive the Hall code of sector ns and check every cycle against the expected timeline.
    task automatic step_to(input int ns, input int hold);
        int prev;
        int esec;
        logic pwm, es;
        logic [5:0] eg;
        prev = cur_sec;
        HALL = codes[ns];
        for (int c = 1; c <= hold; c++) begin
            pwm = 1'($urandom);
            PWM = pwm;
            tick();
            if (c < 2 + DB) begin
                eg = pat(prev, cur_dir, pwm); es = 1'b0; esec = prev;
            end else if (c < 2 + DB + DT) begin
                eg = 6'b0; es = (c == 2 + DB); esec = ns;
            end else begin
                eg = pat(ns, cur_dir, pwm); es = 1'b0; esec = ns;
            end
            chk++; if (gates !== eg) $display("FAIL step_gates %0d->%0d c=%0d: got %b expected %b", prev, ns, c, gates, eg); else pass++;
            chk++; if (STEP !== es) $display("FAIL step_pulse %0d->%0d c=%0d: got %b expected %b", prev, ns, c, STEP, es); else pass++;
            chk++; if (SECTOR !== 3'(esec)) $display("FAIL step_sector %0d->%0d c=%0d: got %0d expected %0d", prev, ns, c, SECTOR, esec); else pass++;
        end
        cur_sec = ns;
    endtask

    task automatic test_forward();
        for (int i = 1; i <= 6; i++) step_to(i % 6, 200);
    endtask

    task automatic test_back_to_back();
        int ns;
        for (int i = 0; i < 10; i++) begin
            ns = ($urandom_range(0, 1) == 1) ? (cur_sec + 1) % 6 : (cur_sec + 5) % 6;
            step_to(ns, $urandom_range(10, 60));
        end
        while (cur_sec != 2) step_to((cur_sec + 1) % 6, 30);
    endtask

    task automatic test_reverse();
        logic [5:0] eg;
        DIR = 1'b1;
        cur_dir = 1'b1;
        for (int c = 1; c <= DT + 20; c++) begin
            PWM = ~PWM;
            tick();
            eg = (c <= DT) ? 6'b0 : pat(2, 1'b1, PWM);
            chk++; if (gates !== eg) $display("FAIL reverse_gates c=%0d: got %b expected %b", c, gates, eg); else pass++;
        end
        chk++; if (BL !== 1'b1) $display("FAIL reverse_bl: got %b expected 1", BL); else pass++;
        DIR = 1'b0;
        repeat (2) begin
            tick();
            chk++; if (gates !== 6'b0) $display("FAIL dir_dead_gates: got %b expected 000000", gates); else pass++;
        end
        DIR = 1'b1;
        for (int c = 1; c <= DT + 3; c++) begin
            PWM = 1'($urandom);
            tick();
            eg = (c <= DT) ? 6'b0 : pat(2, 1'b1, PWM);
            chk++; if (gates !== eg) $display("FAIL dir_restart c=%0d: got %b expected %b", c, gates, eg); else pass++;
        end
    endtask

    task automatic test_glitch();
        logic [5:0] eg;
        HALL = codes[3];
        for (int c = 1; c <= 22; c++) begin
            if (c == 3) HALL = codes[2];
            PWM = 1'($urandom);
            tick();
            eg = pat(2, 1'b1, PWM);
            chk++; if (gates !== eg) $display("FAIL glitch_gates c=%0d: got %b expected %b", c, gates, eg); else pass++;
            chk++; if (STEP !== 1'b0) $display("FAIL glitch_step c=%0d: got %b expected 0", c, STEP); else pass++;
            chk++; if (SECTOR !== 3'd2) $display("FAIL glitch_sector c=%0d: got %0d expected 2", c, SECTOR); else pass++;
        end
    endtask

    task automatic test_en_drop();
        logic [5:0] eg;
        EN = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            PWM = 1'($urandom);
            tick();
            chk++; if (gates !== 6'b0) $display("FAIL en_drop c=%0d: got %b expected 000000", c, gates); else pass++;
        end
        EN = 1'b1;
        for (int c = 1; c <= DT + 5; c++) begin
            PWM = 1'($urandom);
            tick();
            eg = (c <= DT) ? 6'b0 : pat(2, 1'b1, PWM);
            chk++; if (gates !== eg) $display("FAIL en_rise c=%0d: got %b expected %b", c, gates, eg); else pass++;
        end
    endtask

    task automatic test_invalid();
        HALL = 3'b111;
        for (int c = 1; c <= 2 + DB; c++) begin
            PWM = 1'($urandom);
            tick();
            if (c < 2 + DB) begin
                chk++; if (FAULT !== 1'b0) $display("FAIL invalid_early c=%0d: got %b expected 0", c, FAULT); else pass++;
            end
        end
        chk++; if (FAULT !== 1'b1) $display("FAIL invalid_fault: got %b expected 1", FAULT); else pass++;
        chk++; if (gates !== 6'b0) $display("FAIL invalid_gates: got %b expected 000000", gates); else pass++;
        chk++; if (SECTOR !== 3'd2) $display("FAIL invalid_sector: got %0d expected 2", SECTOR); else pass++;
        EN = 1'b0;
        repeat (3) tick();
        EN = 1'b1;
        repeat (10) tick();
        chk++; if (FAULT !== 1'b1) $display("FAIL fault_sticky: got %b expected 1", FAULT); else pass++;
        chk++; if (gates !== 6'b0) $display("FAIL fault_gates: got %b expected 000000", gates); else pass++;
        RST = 1'b1;
        tick();
        chk++; if (FAULT !== 1'b0) $display("FAIL rst_fault: got %b expected 0", FAULT); else pass++;
        chk++; if (SECTOR !== 3'd0) $display("FAIL rst_sector: got %0d expected 0", SECTOR); else pass++;
    endtask

    task automatic test_jump();
        do_reset();
        RST = 1'b0; HALL = 3'b101; EN = 1'b1; DIR = 1'b0; PWM = 1'b1;
        repeat (2 + DB + DT + 3) tick();
        HALL = 3'b110;
        for (int c = 1; c <= 2 + DB; c++) begin
            tick();
            if (c == 2 + DB - 1) begin
                chk++; if (FAULT !== 1'b0) $display("FAIL jump_early: got %b expected 0", FAULT); else pass++;
            end
        end
        chk++; if (FAULT !== 1'b1) $display("FAIL jump_fault: got %b expected 1", FAULT); else pass++;
        chk++; if (SECTOR !== 3'd2) $display("FAIL jump_sector: got %0d expected 2", SECTOR); else pass++;
        chk++; if (STEP !== 1'b0) $display("FAIL jump_step: got %b expected 0", STEP); else pass++;
        chk++; if (gates !== 6'b0) $display("FAIL jump_gates: got %b expected 000000", gates); else pass++;
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        RST = 1'b0; HALL = 3'b101; EN = 1'b1; DIR = 1'b0; PWM = 1'b1;
        n = 0;
        while (s_FAULT !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk++; if (n !== 2 + DB + SLIM) $display("FAIL stall_cycles: got %0d expected %0d", n, 2 + DB + SLIM); else pass++;
        chk++; if (FAULT !== 1'b0) $display("FAIL stall_main_nofault: got %b expected 0", FAULT); else pass++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_forward();
        test_back_to_back();
        test_reverse();
        test_glitch();
        test_en_drop();
        test_invalid();
        test_jump();
        test_stall();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
